// File: rtl/speech256_pkg.sv
// speech256_pkg: shared constants and types for the speech excitation source
//   SAMPLE_W/PERIOD_W/LFSR_W : datapath widths
//   NOISE_PERIOD             : samples per noise period
//   LFSR_SEED/LFSR_TAPS      : 17-bit Fibonacci LFSR seed and tap mask (taps 17,14)
//   state_t                  : source generator FSM states
package speech256_pkg;
    localparam int SAMPLE_W = 16;
    localparam int PERIOD_W = 8;
    localparam int LFSR_W = 17;
    localparam logic [PERIOD_W-1:0] NOISE_PERIOD = 8'd64;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 17'h1ACE1;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 17'h12000;
    typedef enum logic [1:0] {IDLE, VOICED, NOISE} state_t;
endpackage

// File: rtl/source_lfsr.sv
// source_lfsr: 17-bit Fibonacci LFSR noise source (taps 17,14)
//   clk   : clock
//   rst   : sync active-high reset, loads LFSR_SEED
//   adv   : advance one step
//   state : current LFSR state
module source_lfsr
    import speech256_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              adv,
    output logic [LFSR_W-1:0] state
);
    always_ff @(posedge clk) begin
        if (rst)
            state <= LFSR_SEED;
        else if (state == '0)
            state <= LFSR_SEED;  // lock-up escape
        else if (adv)
            state <= {state[LFSR_W-2:0], ^(state & LFSR_TAPS)};
    end
endmodule

// File: rtl/source_gen.sv
// source_gen: pitch-impulse / noise excitation generator
//   clk, rst     : clock, sync active-high reset
//   strobe       : sample tick; outputs update the following clk
//   period_in    : pitch period in samples, 0 selects noise
//   amp_in       : unsigned amplitude, sampled every strobe
//   clear        : return to IDLE and restart the period
//   source_out   : signed excitation sample
//   period_done  : one-clk pulse with the last sample of a period
// Macro SOURCE_SAT_EN: defined -> A=min(amp_in,32767); undefined -> A=amp_in>>1
module source_gen
    import speech256_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                strobe,
    input  logic [PERIOD_W-1:0] period_in,
    input  logic [SAMPLE_W-1:0] amp_in,
    input  logic                clear,
    output logic [SAMPLE_W-1:0] source_out,
    output logic                period_done
);
    state_t              state;
    logic [PERIOD_W-1:0] cnt, period_l, per;
    logic [LFSR_W-1:0]   lfsr;
    logic [SAMPLE_W-1:0] a;
    logic                noise_m, last, adv, sign;

    source_lfsr u_lfsr (.clk(clk), .rst(rst), .adv(adv), .state(lfsr));

    // In IDLE the first strobe starts a period straight from period_in.
    always_comb begin
        noise_m = (state == IDLE) ? (period_in == '0) : (state == NOISE);
        per     = (state == IDLE) ? period_in : period_l;
        last    = noise_m ? (cnt == NOISE_PERIOD - 8'd1) : (cnt == per - 8'd1);
        adv     = strobe && !clear && noise_m;
        sign    = |(lfsr & LFSR_W'(1));
`ifdef SOURCE_SAT_EN
        a = (amp_in > 16'd32767) ? 16'd32767 : amp_in;
`else
        a = amp_in >> 1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            period_l    <= '0;
            source_out  <= '0;
            period_done <= 1'b0;
        end else if (clear) begin
            state       <= IDLE;
            cnt         <= '0;
            source_out  <= '0;
            period_done <= 1'b0;
        end else if (strobe) begin
            source_out  <= noise_m ? (sign ? a : 16'd0 - a) : ((cnt == '0) ? a : '0);
            period_done <= last;
            cnt         <= last ? '0 : cnt + 8'd1;
            if (last || state == IDLE) begin
                period_l <= period_in;
                state    <= (period_in != '0) ? VOICED : NOISE;
            end
        end else begin
            period_done <= 1'b0;
        end
    end
endmodule

// File: tb/tb_source_gen.sv
// tb_source_gen: randomized + directed self-checking bench for source_gen
module tb_source_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        strobe = 1'b0;
    logic [7:0]  period_in = 8'd0;
    logic [15:0] amp_in = 16'd0;
    logic        clear = 1'b0;
    logic [15:0] source_out;
    logic        period_done;

    int tests = 0;
    int fails = 0;

    // reference model: period bookkeeping in plain integers
    bit          m_idle = 1'b1;
    int          m_cur = 0;
    int          m_idx = 0;
    logic [16:0] m_lfsr = 17'h1ACE1;
    logic [15:0] last_o = 16'd0;
    logic [15:0] eo;
    logic        ed;
    longint      noise_sum;

    source_gen dut (
        .clk(clk), .rst(rst), .strobe(strobe), .period_in(period_in),
        .amp_in(amp_in), .clear(clear), .source_out(source_out), .period_done(period_done)
    );

    always #5 clk = ~clk;

    function automatic int amp(input logic [15:0] x);
`ifdef SOURCE_SAT_EN
        return (int'(x) > 32767) ? 32767 : int'(x);
`else
        return int'(x) / 2;
`endif
    endfunction

    function automatic logic [16:0] lfsr_next(input logic [16:0] s);
        int v, n;
        v = int'(s);
        n = ((v * 2) + (((v / 65536) ^ (v / 8192)) % 2)) % 131072;
        return (n == 0) ? 17'h1ACE1 : 17'(n);
    endfunction

    task automatic model_strobe(input logic [7:0] p, input logic [15:0] a,
                                output logic [15:0] o, output logic d);
        int av, len;
        if (m_idle) begin
            m_cur = int'(p);
            m_idx = 0;
            m_idle = 1'b0;
        end
        av = amp(a);
        len = (m_cur == 0) ? 64 : m_cur;
        if (m_cur == 0) begin
            o = m_lfsr[0] ? 16'(av) : 16'(-av);
            m_lfsr = lfsr_next(m_lfsr);
        end else begin
            o = (m_idx == 0) ? 16'(av) : 16'd0;
        end
        d = (m_idx == len - 1);
        m_idx++;
        if (d) begin
            m_idx = 0;
            m_cur = int'(p);
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // one 10-clk sample slot: drive, check the update, then check hold
    task automatic step(input logic stb, input logic clr, input logic [7:0] p, input logic [15:0] a);
        @(negedge clk);
        strobe = stb;
        clear = clr;
        period_in = p;
        amp_in = a;
        if (clr) begin
            m_idle = 1'b1;
            m_idx = 0;
            eo = 16'd0;
            ed = 1'b0;
        end else if (stb) begin
            model_strobe(p, a, eo, ed);
        end else begin
            eo = last_o;
            ed = 1'b0;
        end
        @(posedge clk);
        #1;
        strobe = 1'b0;
        clear = 1'b0;
        chk("source_out", source_out, eo);
        chk("period_done", {15'd0, period_done}, {15'd0, ed});
        last_o = eo;
        @(negedge clk);
        amp_in = 16'($urandom);
        period_in = 8'($urandom);
        repeat (8) @(posedge clk);
        #1;
        chk("hold_out", source_out, last_o);
        chk("hold_done", {15'd0, period_done}, 16'd0);
    endtask

    task automatic do_reset(input logic stb);
        @(negedge clk);
        rst = 1'b1;
        strobe = stb;
        clear = stb;
        @(posedge clk);
        #1;
        rst = 1'b0;
        strobe = 1'b0;
        clear = 1'b0;
        m_idle = 1'b1;
        m_idx = 0;
        m_lfsr = 17'h1ACE1;
        last_o = 16'd0;
        chk("rst_out", source_out, 16'd0);
        chk("rst_done", {15'd0, period_done}, 16'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", source_out, 16'd0);
        chk("reset_done", {15'd0, period_done}, 16'd0);
        @(negedge clk);
        rst = 1'b0;

        // voiced period 4
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 8'd4, 16'd1000);

        // period 1: every sample an impulse with period_done
        step(1'b0, 1'b1, 8'd1, 16'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'd1, 16'd3000);

        // mid-period change 8 -> 3 at sample 2
        step(1'b0, 1'b1, 8'd8, 16'd0);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 8'd8, 16'd1000);
        for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 8'd3, 16'd1000);

        // clear coincident with strobe at sample 5 of period 10
        step(1'b0, 1'b1, 8'd10, 16'd0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'd10, 16'd1000);
        step(1'b1, 1'b1, 8'd10, 16'd1000);
        step(1'b1, 1'b0, 8'd10, 16'd1000);

        // saturation in noise mode
        step(1'b0, 1'b1, 8'd0, 16'd0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'd0, 16'd40000);
        tests++;
`ifdef SOURCE_SAT_EN
        assert (source_out === 16'd32767 || source_out === 16'h8001) else begin
`else
        assert (source_out === 16'd20000 || source_out === 16'(-20000)) else begin
`endif
            fails++;
            $error("FAIL sat_value observed=%0h", source_out);
        end

        // reset at sample 3 of a voiced period (strobe and clear also high), then noise from seed
        step(1'b0, 1'b1, 8'd5, 16'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'd5, 16'd1000);
        do_reset(1'b1);

        // noise run: values checked per sample by the model, plus mean
        noise_sum = 0;
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, 1'b0, 8'd0, 16'd500);
            noise_sum += longint'($signed(source_out));
        end
        tests++;
        assert (noise_sum <= 100 * amp(16'd500) && noise_sum >= -100 * amp(16'd500)) else begin
            fails++;
            $error("FAIL noise_mean observed_sum=%0d limit=%0d", noise_sum, 100 * amp(16'd500));
        end

        // randomized mix of periods, amplitudes, idle slots and clears
        for (int i = 0; i < 300; i++) begin
            logic [7:0] p;
            logic       s, c;
            p = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
            c = ($urandom_range(0, 19) == 0);
            s = ($urandom_range(0, 7) != 0);
            step(s, c, p, 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
